hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//   Parametrised hazard and forwarding unit for the 5-stage GP/FP integer-float pipeline.
//   Keeps a shadow pipe of in-flight register writers for the stages after ID (EX..WB).
//   Each cycle it produces, for the instruction in ID:
//     - a stall request (hold IF/ID, insert a bubble into EX);
//     - per-operand forwarding codes.
//   Squashes younger shadow entries on a taken branch or jump redirect. Counts stall cycles.
// PARAMETERS
//   REG_ADDR_W     5  register index width (GP and FP files are equal size)
//   DEPTH          3  tracked stages after ID (entry 0=EX, 1=MEM, DEPTH-1=WB)
//   ALU_LAT        1  non-load result forwardable once producer entry index >= ALU_LAT-1
//   LOAD_LAT       2  load result forwardable once producer entry index >= LOAD_LAT-1
//   RESOLVE_STAGE  2  entry index at which a redirect resolves; entries < this are squashed
//   FWD_W          $clog2(DEPTH+1)  forwarding code width (derived, do not override)
// PORTS
//   clock        in   1           system clock
//   reset        in   1           synchronous, active-high
//   id_valid     in   1           ID holds a real instruction
//   id_rs        in   REG_ADDR_W  source A index
//   id_rs_used   in   1           source A is read
//   id_rs_fp     in   1           source A is in the FP file
//   id_rt        in   REG_ADDR_W  source B index
//   id_rt_used   in   1           source B is read
//   id_rt_fp     in   1           source B is in the FP file
//   id_rd        in   REG_ADDR_W  destination index
//   id_wr_en     in   1           instruction writes id_rd
//   id_rd_fp     in   1           destination is in the FP file
//   id_is_load   in   1           destination data comes from DMEM
//   redirect     in   1           taken branch or jump resolving this cycle
//   stall        out  1           hold PC and IF/ID; zero the ID/EX control
//   fwd_a        out  FWD_W       source A forwarding code
//   fwd_b        out  FWD_W       source B forwarding code
//   stall_count  out  32          saturating count of stall cycles
// BEHAVIOUR
//   Shadow entry fields: {valid, wr, fp, rd, load}.
//   Every clock: e[i+1] <= e[i]; e[DEPTH-1] retires.
//   e[0] <= the ID instruction when id_valid & ~stall & ~redirect; otherwise a bubble (valid=0).
//   A GP write to r0 is recorded with wr=0. FP f0 is a real register.
//   Match, per source: used & e[i].valid & e[i].wr & fp bits equal & index equal.
//   The youngest match (lowest i) decides. Older matches are ignored.
//   Ready test: i >= (e[i].load ? LOAD_LAT-1 : ALU_LAT-1).
//     - Youngest match not ready: stall=1.
//     - Youngest match ready: fwd=i+1.
//     - No match: fwd=0.
//   Code meanings:
//     - fwd code k in 1..DEPTH-1 selects the stage-k pipeline register when the consumer is in EX.
//     - fwd code DEPTH means the producer retires this cycle; the datapath substitutes bus_w/fbus_w
//       when capturing ID/EX operands.
//     - fwd code 0 means use the register file.
//   stall = id_valid & ~redirect & (hazard on A | hazard on B). It is combinational, same cycle.
//   redirect: at the next edge, entries with index < RESOLVE_STAGE become invalid (after the shift),
//     and ID is not inserted. redirect overrides stall.
//   Outputs are don't-care to the datapath while stall=1, but must still follow the rules above.
//   Each stall adds exactly one bubble, so a load-use hazard stalls LOAD_LAT-ALU_LAT cycles at most.
//   stall_count increments on every edge where stall=1 and holds at 32'hFFFF_FFFF.
//   Reset: all entries invalid, stall_count=0, so stall=0 and fwd_a=fwd_b=0 in the cycle after reset.
//     Reset mid-stall drops the stall on the next cycle.
// TESTING
//   1. ALU writes r3, next ALU reads r3 as rs -> stall=0, fwd_a=1, fwd_b=0.
//   2. lw r5, next reads r5 as rt -> stall=1 for 1 cycle, then fwd_b=2;
//      stall_count=1; one bubble is seen in e[0].
//   3. ALU r7 at e[1] and ALU r7 at e[0], ID reads r7 -> fwd_a=1 (youngest wins), no stall.
//   4. Writer r0 (GP), ID reads GP r0 -> fwd=0. Writer FP f4, ID reads GP r4 -> fwd=0.
//      Writer FP f4, ID reads FP f4 -> fwd=1.
//   5. Load-use hazard plus redirect=1 -> stall=0.
//      Next cycle e[0] and e[1] are invalid, the previous e[1] is now in e[2] and still valid.
//   6. reset asserted during a stall -> next cycle stall=0, fwd=0, stall_count=0.
//      Force 2^32 stalls (or preload the counter) -> holds at FFFF_FFFF.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage request and hazard/forwarding response bundle
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_W      = 2
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic                  id_rs_used;
  logic                  id_rs_fp;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_rt_used;
  logic                  id_rt_fp;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_wr_en;
  logic                  id_rd_fp;
  logic                  id_is_load;
  logic                  redirect;
  logic                  stall;
  logic [FWD_W-1:0]      fwd_a;
  logic [FWD_W-1:0]      fwd_b;
  logic [31:0]           stall_count;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rs_fp, id_rt, id_rt_used, id_rt_fp,
    output id_rd, id_wr_en, id_rd_fp, id_is_load, redirect,
    input  stall, fwd_a, fwd_b, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rs_fp, id_rt, id_rt_used, id_rt_fp,
    input  id_rd, id_wr_en, id_rd_fp, id_is_load, redirect,
    output stall, fwd_a, fwd_b, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - shadow pipe of in-flight writers producing stall and forwarding codes
// Entry 0 is EX, entry DEPTH-1 is WB; the youngest matching writer decides each operand.
module hazard_scoreboard #(
  parameter int REG_ADDR_W    = 5,
  parameter int DEPTH         = 3,
  parameter int ALU_LAT       = 1,
  parameter int LOAD_LAT      = 2,
  parameter int RESOLVE_STAGE = 2
) (
  input logic             clock,
  input logic             reset,
  hazard_scoreboard_if.slave sb
);
  localparam int FWD_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic                  fp;
    logic [REG_ADDR_W-1:0] rd;
    logic                  load;
  } entry_t;

  entry_t           e [DEPTH];
  entry_t           ins;
  logic             haz_a, haz_b, stall_c;
  logic [FWD_W-1:0] code_a, code_b;
  logic [31:0]      stall_count_q;

  // Walk oldest to youngest so the lowest-index match is the one that sticks.
  always_comb begin
    haz_a  = 1'b0;
    haz_b  = 1'b0;
    code_a = '0;
    code_b = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (sb.id_rs_used && e[i].valid && e[i].wr && (e[i].fp == sb.id_rs_fp) && (e[i].rd == sb.id_rs)) begin
        if (i >= (e[i].load ? LOAD_LAT - 1 : ALU_LAT - 1)) begin
          haz_a  = 1'b0;
          code_a = FWD_W'(i + 1);
        end else begin
          haz_a  = 1'b1;
          code_a = '0;
        end
      end
      if (sb.id_rt_used && e[i].valid && e[i].wr && (e[i].fp == sb.id_rt_fp) && (e[i].rd == sb.id_rt)) begin
        if (i >= (e[i].load ? LOAD_LAT - 1 : ALU_LAT - 1)) begin
          haz_b  = 1'b0;
          code_b = FWD_W'(i + 1);
        end else begin
          haz_b  = 1'b1;
          code_b = '0;
        end
      end
    end
  end

  assign stall_c = sb.id_valid & ~sb.redirect & (haz_a | haz_b);

  // GP r0 is hardwired, so a write to it never produces a dependency.
  always_comb begin
    ins = '0;
    if (sb.id_valid && !stall_c && !sb.redirect) begin
      ins.valid = 1'b1;
      ins.wr    = sb.id_wr_en & ~(~sb.id_rd_fp & (sb.id_rd == '0));
      ins.fp    = sb.id_rd_fp;
      ins.rd    = sb.id_rd;
      ins.load  = sb.id_is_load;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) e[i] <= '0;
      stall_count_q <= '0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        e[i] <= e[i-1];
        if (sb.redirect && (i < RESOLVE_STAGE)) e[i].valid <= 1'b0;
      end
      e[0] <= ins;
      if (stall_c && (stall_count_q != 32'hFFFF_FFFF)) stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign sb.stall       = stall_c;
  assign sb.fwd_a       = code_a;
  assign sb.fwd_b       = code_b;
  assign sb.stall_count = stall_count_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed bench for hazard_scoreboard
module tb_hazard_scoreboard;
  logic clock = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clock = ~clock;

  hazard_scoreboard_if #(.REG_ADDR_W(5), .FWD_W(2)) sb_if ();

  hazard_scoreboard dut (
    .clock (clock),
    .reset (reset),
    .sb    (sb_if.slave)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic rsu, input logic rsf,
                       input logic [4:0] rt, input logic rtu, input logic rtf,
                       input logic [4:0] rd, input logic wr, input logic rdf, input logic ld);
    sb_if.id_valid   = v;
    sb_if.id_rs      = rs;
    sb_if.id_rs_used = rsu;
    sb_if.id_rs_fp   = rsf;
    sb_if.id_rt      = rt;
    sb_if.id_rt_used = rtu;
    sb_if.id_rt_fp   = rtf;
    sb_if.id_rd      = rd;
    sb_if.id_wr_en   = wr;
    sb_if.id_rd_fp   = rdf;
    sb_if.id_is_load = ld;
    #2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic flush();
    idle();
    repeat (3) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1;
    sb_if.redirect = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #2;
    check("reset_stall", 32'(sb_if.stall), 0);
    check("reset_fwd_a", 32'(sb_if.fwd_a), 0);
    check("reset_count", sb_if.stall_count, 0);

    // ALU r3 then reader of r3 as rs
    drive(1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0);
    tick();
    drive(1, 3, 1, 0, 1, 1, 0, 9, 1, 0, 0);
    check("alu_stall", 32'(sb_if.stall), 0);
    check("alu_fwd_a", 32'(sb_if.fwd_a), 1);
    check("alu_fwd_b", 32'(sb_if.fwd_b), 0);
    tick();
    flush();

    // load-use on rt: one stall cycle, then forward from stage 2
    drive(1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 1);
    tick();
    drive(1, 1, 1, 0, 5, 1, 0, 6, 1, 0, 0);
    check("lu_stall", 32'(sb_if.stall), 1);
    check("lu_count0", sb_if.stall_count, 0);
    tick();
    check("lu_stall_drop", 32'(sb_if.stall), 0);
    check("lu_fwd_b", 32'(sb_if.fwd_b), 2);
    check("lu_fwd_a", 32'(sb_if.fwd_a), 0);
    check("lu_count1", sb_if.stall_count, 1);
    tick();
    flush();

    // two writers of r7: youngest wins
    drive(1, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0);
    tick();
    drive(1, 7, 1, 0, 7, 1, 0, 8, 1, 0, 0);
    check("young_stall", 32'(sb_if.stall), 0);
    check("young_fwd_a", 32'(sb_if.fwd_a), 1);
    check("young_fwd_b", 32'(sb_if.fwd_b), 1);
    tick();
    flush();

    // r0 writer is ignored; FP/GP files are distinct; f0 is real
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("r0_fwd_a", 32'(sb_if.fwd_a), 0);
    check("r0_stall", 32'(sb_if.stall), 0);
    drive(1, 0, 0, 0, 0, 0, 0, 4, 1, 1, 0);
    tick();
    drive(1, 4, 1, 0, 4, 1, 1, 0, 1, 1, 0);
    check("gp4_vs_fp4", 32'(sb_if.fwd_a), 0);
    check("fp4_fwd_b", 32'(sb_if.fwd_b), 1);
    tick();
    drive(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("f0_fwd_a", 32'(sb_if.fwd_a), 1);
    tick();
    flush();

    // redirect overrides a load-use stall and squashes EX/MEM
    drive(1, 0, 0, 0, 0, 0, 0, 9, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 1);
    tick();
    drive(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    check("rd_pre_stall", 32'(sb_if.stall), 1);
    sb_if.redirect = 1'b1;
    #1;
    check("rd_stall", 32'(sb_if.stall), 0);
    tick();
    sb_if.redirect = 1'b0;
    drive(1, 9, 1, 0, 5, 1, 0, 0, 0, 0, 0);
    check("rd_survivor", 32'(sb_if.fwd_a), 3);
    check("rd_squashed", 32'(sb_if.fwd_b), 0);
    check("rd_no_stall", 32'(sb_if.stall), 0);
    check("rd_count", sb_if.stall_count, 1);
    tick();
    flush();

    // reset in the middle of a stall
    drive(1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 1);
    tick();
    drive(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    check("rst_pre_stall", 32'(sb_if.stall), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst_stall", 32'(sb_if.stall), 0);
    check("rst_fwd_b", 32'(sb_if.fwd_b), 0);
    check("rst_count", sb_if.stall_count, 0);
    flush();

    // counter saturation from a preloaded value
    drive(1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 1);
    tick();
    drive(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    force dut.stall_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_count_q;
    #1;
    check("sat_preload", sb_if.stall_count, 32'hFFFF_FFFE);
    tick();
    check("sat_max", sb_if.stall_count, 32'hFFFF_FFFF);
    drive(1, 0, 0, 0, 0, 0, 0, 6, 1, 0, 1);
    tick();
    drive(1, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0);
    check("sat_stall", 32'(sb_if.stall), 1);
    tick();
    check("sat_hold", sb_if.stall_count, 32'hFFFF_FFFF);
    flush();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
